mux_display_driver: RTL and testbench
=====================================

# mux_display_driver

Parametrised time-multiplexed N-digit seven-segment driver for the Poncho display path. It is the successor to the fixed 4-digit driver and adds:
- a configurable digit count;
- a per-frame coherent input snapshot;
- per-digit blanking;
- PWM brightness control;
- a frame-start strobe.

It sits between the counter/arithmetic logic and the board's digit-enable and segment pins.

## Interface
- N_DIGITS, 4, number of multiplexed digits (2..8)
- PRESCALER_BITS, 16, width of the slot prescaler; each digit slot lasts 2^PRESCALER_BITS clocks
- BRIGHT_BITS, 3, brightness resolution; PRESCALER_BITS >= BRIGHT_BITS is required

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- hex_in  in  4*N_DIGITS  packed nibbles; digit i = hex_in[4i+3:4i], digit 0 rightmost
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  N_DIGITS  1 = digit dark for the whole frame
- brightness  in  BRIGHT_BITS  duty code; 0 = dimmest, all-ones = full on
- en_disp  out  N_DIGITS  one-hot digit enable, active-high, registered
- digit_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered
- frame_start  out  1  one-clock pulse on the cycle the snapshot is taken

## Operation
Counters:
- Prescaler `pre` counts 0..2^PRESCALER_BITS-1 and wraps.
- Digit index `idx` counts 0..N_DIGITS-1. It increments when `pre` wraps and wraps from N_DIGITS-1 to 0.
- There is no FSM beyond these two counters.

Frame start and snapshot:
- frame_start = (pre==0 && idx==0). This includes the first cycle after reset release.
- On that cycle, hex_in, dp_in, blank_in and brightness are registered into snapshot registers.
- Input changes at any other time are ignored until the next frame.

PWM gating:
- pwm field = pre[PRESCALER_BITS-1 -: BRIGHT_BITS].
- The slot is lit while field <= snapshot brightness.
- Lit duty = (brightness+1)/2^BRIGHT_BITS.

Per-cycle output, for the delayed counter state:
- If the slot is lit and the digit is not blanked: en_disp = one-hot(idx), and digit_out = {dp[idx], seg(hex[idx])}.
- Otherwise: en_disp = 0 and digit_out = 8'h00.
- Segments use the standard hex font. Examples: 0 → 0x3F, 1 → 0x06, 5 → 0x6D, A → 0x77, F → 0x71.

Reset and width rules:
- Reset clears pre, idx, all snapshots, the delay registers, en_disp, digit_out and frame_start to 0.
- Reset mid-frame aborts the scan. Outputs go dark on the next clock; a fresh frame starts with a snapshot on the first cycle after release.
- All counters are unsigned and wrap naturally. idx wraps explicitly at N_DIGITS-1, because N_DIGITS need not be a power of two.

## Timing
- frame_start is combinational from the counters and is not delayed.
- Pin latency is 2 clocks: en_disp/digit_out at cycle t reflect counter state at t-2.
- A snapshot taken in frame_start cycle c0 appears on the pins at c0+2.
- Slot length is 2^PRESCALER_BITS clocks; frame length is N_DIGITS*2^PRESCALER_BITS clocks.
- en_disp is never multi-hot, including across slot boundaries and reset.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits are scanned from N_DIGITS-1 downward on the snapshot.
  - A digit with hex==0 and dp==0 is treated as blank_in=1 until the first non-qualifying digit is reached.
  - Digit 0 is never suppressed.
- LEADING_ZERO_BLANK_EN undefined: zeros display normally; only blank_in darkens digits.

## Structure
- Package mux_display_pkg holds:
  - the 16-entry segment font constant;
  - SEG_DP bit index (7);
  - the all-off segment constant.
- Sub-module: the existing hex_to_7seg, instantiated once on the mux-selected snapshot nibble.
- Prescaler, scan, snapshot and PWM logic stay in mux_display_driver.

## Test plan
All scenarios use N_DIGITS=4, PRESCALER_BITS=4, BRIGHT_BITS=2 (slot = 16 clk, frame = 64 clk).
- Reset, then release with hex_in=16'hFA51, dp_in=4'hA, brightness=3 → frame_start pulses on the first cycle after release. Two clocks later en_disp=0001, digit_out=0x06 for 16 clk. Next slots: 0010 with 0xED, 0100 with 0x77, 1000 with 0xF1.
- Change hex_in to 16'h0000 at slot 2 mid-frame → the displayed digits are unchanged until the next frame_start; the next frame shows 0x3F on all digits (macro off).
- brightness=1 → each slot has en_disp one-hot for 8 clk, then en_disp=0 and digit_out=0x00 for 8 clk; brightness=0 → 4 clk lit.
- blank_in=4'b0100 → the digit-2 slot stays en_disp=0, digit_out=0x00 for all 16 clk; other slots are normal.
- With LEADING_ZERO_BLANK_EN, hex_in=16'h0050, dp_in=0 → digits 3 and 2 are dark, digit 1 shows 0x6D, digit 0 shows 0x3F. With hex_in=0 → only digit 0 is lit, showing 0x3F.
- Assert rst for one cycle mid-slot → outputs are 0 on the next clock. frame_start pulses on the first cycle after release, and the scan restarts at digit 0; en_disp is never multi-hot at any point.

Source files
------------

// File: rtl/mux_display_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high.
package mux_display_pkg;

    localparam int SEG_DP = 7;
    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to seven-segment decoder (segments g..a, active-high).
import mux_display_pkg::*;

module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_FONT[hex];

endmodule

// File: rtl/mux_display_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-frame snapshot, blanking and PWM dimming.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
import mux_display_pkg::*;

module mux_display_driver #(
    parameter int N_DIGITS       = 4,
    parameter int PRESCALER_BITS = 16,
    parameter int BRIGHT_BITS    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [N_DIGITS-1:0]     en_disp,
    output logic [7:0]              digit_out,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRESCALER_BITS-1:0] pre;
    logic [IDX_W-1:0]          idx;

    logic [4*N_DIGITS-1:0]     snap_hex;
    logic [N_DIGITS-1:0]       snap_dp;
    logic [N_DIGITS-1:0]       snap_blank;
    logic [BRIGHT_BITS-1:0]    snap_bright;

    logic                      valid_d;
    logic [IDX_W-1:0]          idx_d;
    logic [BRIGHT_BITS-1:0]    field_d;

    logic [N_DIGITS-1:0]       blank_eff;
    logic [3:0]                sel_hex;
    logic [6:0]                sel_seg;
    logic                      slot_on;
    logic [7:0]                digit_next;

    assign frame_start = ~rst & (pre == '0) & (idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (pre == '1)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_hex    <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_bright <= '0;
        end else if (frame_start) begin
            snap_hex    <= hex_in;
            snap_dp     <= dp_in;
            snap_blank  <= blank_in;
            snap_bright <= brightness;
        end
    end

    // valid_d keeps the cycle right after reset dark, since the delay stage holds no real scan state yet
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
            idx_d   <= '0;
            field_d <= '0;
        end else begin
            valid_d <= 1'b1;
            idx_d   <= idx;
            field_d <= pre[PRESCALER_BITS-1 -: BRIGHT_BITS];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic leading;

    always_comb begin
        blank_eff = snap_blank;
        leading   = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            leading      = leading & (snap_hex[4*i +: 4] == 4'h0) & ~snap_dp[i];
            blank_eff[i] = blank_eff[i] | leading;
        end
    end
`else
    assign blank_eff = snap_blank;
`endif

    assign sel_hex = snap_hex[idx_d*4 +: 4];

    hex_to_7seg u_hex_to_7seg (
        .hex (sel_hex),
        .seg (sel_seg)
    );

    always_comb begin
        slot_on            = valid_d & (field_d <= snap_bright) & ~blank_eff[idx_d];
        digit_next         = {1'b0, sel_seg};
        digit_next[SEG_DP] = snap_dp[idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_disp   <= '0;
            digit_out <= SEG_OFF;
        end else if (slot_on) begin
            en_disp   <= N_DIGITS'(1) << idx_d;
            digit_out <= digit_next;
        end else begin
            en_disp   <= '0;
            digit_out <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_mux_display_driver.sv
// Directed bench for mux_display_driver at N_DIGITS=4, PRESCALER_BITS=4, BRIGHT_BITS=2.
module tb_mux_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [1:0]  brightness;
    logic [3:0]  en_disp;
    logic [7:0]  digit_out;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_display_driver #(
        .N_DIGITS       (4),
        .PRESCALER_BITS (4),
        .BRIGHT_BITS    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .brightness  (brightness),
        .en_disp     (en_disp),
        .digit_out   (digit_out),
        .frame_start (frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at cycle c0+2 of a frame; checks 64 cycles and leaves at the next frame's c0+2.
    task automatic check_frame(input string name,
                               input logic [7:0] s3, input logic [7:0] s2,
                               input logic [7:0] s1, input logic [7:0] s0,
                               input logic [3:0] blank, input logic [1:0] bright,
                               input int apply_k,
                               input logic [15:0] nh, input logic [3:0] nd,
                               input logic [3:0] nb, input logic [1:0] nbr);
        logic [7:0] segs [4];
        logic [3:0] exp_en;
        logic [7:0] exp_dig;
        logic       exp_fs;
        int slot;
        int field;
        segs = '{s0, s1, s2, s3};
        for (int k = 0; k < 64; k++) begin
            slot    = k / 16;
            field   = (k % 16) / 4;
            exp_en  = (field <= int'(bright) && !blank[slot]) ? 4'(1 << slot) : 4'd0;
            exp_dig = (exp_en != 4'd0) ? segs[slot] : 8'h00;
            exp_fs  = (k == 62);
            checks++;
            if (en_disp !== exp_en) begin
                errors++;
                $display("FAIL %s en_disp k=%0d got %b want %b", name, k, en_disp, exp_en);
            end
            checks++;
            if (digit_out !== exp_dig) begin
                errors++;
                $display("FAIL %s digit_out k=%0d got %h want %h", name, k, digit_out, exp_dig);
            end
            checks++;
            if (frame_start !== exp_fs) begin
                errors++;
                $display("FAIL %s frame_start k=%0d got %b want %b", name, k, frame_start, exp_fs);
            end
            if (k == apply_k) begin
                hex_in     = nh;
                dp_in      = nd;
                blank_in   = nb;
                brightness = nbr;
            end
            step();
        end
    endtask

    task automatic test_reset();
        hex_in     = 16'hFA51;
        dp_in      = 4'hA;
        blank_in   = 4'h0;
        brightness = 2'd3;
        rst        = 1'b1;
        repeat (3) step();
        checks++;
        if (en_disp !== 4'h0 || digit_out !== 8'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got en=%b dig=%h fs=%b want 0000 00 0", en_disp, digit_out, frame_start);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL release_frame_start got %b want 1", frame_start);
        end
        step();
        checks++;
        if (en_disp !== 4'h0 || digit_out !== 8'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL release_latency got en=%b dig=%h fs=%b want 0000 00 0", en_disp, digit_out, frame_start);
        end
        step();
    endtask

    task automatic test_basic();
        check_frame("basic", 8'hF1, 8'h77, 8'hED, 8'h06, 4'b0000, 2'd3,
                    40, 16'h0000, 4'h0, 4'h0, 2'd3);
    endtask

    task automatic test_snapshot();
        check_frame("snapshot", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 4'b0000, 2'd3,
                    20, 16'hFA51, 4'hA, 4'h0, 2'd1);
    endtask

    task automatic test_pwm();
        check_frame("pwm_half", 8'hF1, 8'h77, 8'hED, 8'h06, 4'b0000, 2'd1,
                    10, 16'hFA51, 4'hA, 4'h0, 2'd0);
        check_frame("pwm_min", 8'hF1, 8'h77, 8'hED, 8'h06, 4'b0000, 2'd0,
                    50, 16'hFA51, 4'hA, 4'b0100, 2'd3);
    endtask

    task automatic test_blank();
        check_frame("blank", 8'hF1, 8'h77, 8'hED, 8'h06, 4'b0100, 2'd3,
                    30, 16'h0050, 4'h0, 4'h0, 2'd3);
    endtask

    task automatic test_zeros();
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("lzb_0050", 8'h3F, 8'h3F, 8'h6D, 8'h3F, 4'b1100, 2'd3,
                    5, 16'h0000, 4'h0, 4'h0, 2'd3);
        check_frame("lzb_0000", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 4'b1110, 2'd3,
                    60, 16'hFA51, 4'hA, 4'h0, 2'd3);
`else
        check_frame("zeros_0050", 8'h3F, 8'h3F, 8'h6D, 8'h3F, 4'b0000, 2'd3,
                    5, 16'h0000, 4'h0, 4'h0, 2'd3);
        check_frame("zeros_0000", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 4'b0000, 2'd3,
                    60, 16'hFA51, 4'hA, 4'h0, 2'd3);
`endif
    endtask

    task automatic test_reset_mid();
        repeat (21) begin
            checks++;
            if ($countones(en_disp) > 1) begin
                errors++;
                $display("FAIL mid_onehot got %b want at most one bit", en_disp);
            end
            step();
        end
        rst = 1'b1;
        step();
        checks++;
        if (en_disp !== 4'h0 || digit_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_dark got en=%b dig=%h want 0000 00", en_disp, digit_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL mid_release_frame_start got %b want 1", frame_start);
        end
        step();
        checks++;
        if (en_disp !== 4'h0 || digit_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_release_latency got en=%b dig=%h want 0000 00", en_disp, digit_out);
        end
        step();
        check_frame("after_reset", 8'hF1, 8'h77, 8'hED, 8'h06, 4'b0000, 2'd3,
                    100, 16'hFA51, 4'hA, 4'h0, 2'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_pwm();
        test_blank();
        test_zeros();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
